vram_host_reader: RTL and testbench

VRAM_HOST_READER -- requirements
Module: vram_host_reader

---
 rtl/icevga_pkg.sv | 16 +
 rtl/strobe_sync.sv | 33 +++
 rtl/vram_host_reader.sv | 105 ++++++++++
 tb/tb_vram_host_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/icevga_pkg.sv
// Shared definitions for the icevga host-side VRAM access path.
package icevga_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_SLOT = 3'd1,
      ISSUE     = 3'd2,
      CAPTURE   = 3'd3,
      DRIVE     = 3'd4,
      TURN      = 3'd5
   } rd_state_t;

   localparam logic [2:0] RD_SLOT_DEFAULT = 3'd7;
   localparam int         VRAM_AW         = 13;

endpackage

// File: rtl/strobe_sync.sv
// Multi-stage synchronizer for an active-low asynchronous strobe, with a
// registered rising-edge pulse on the synchronized (active-high) request.
module strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe_n,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_q;

   assign level = ~sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         level_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_q[0] <= strobe_n;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         level_q <= level;
         rise    <= level & ~level_q;
      end
   end

endmodule

// File: rtl/vram_host_reader.sv
// Host read path into VRAM: borrows the display read port in a free readout
// slot, captures the byte and drives it onto the host bus until the strobe ends.
module vram_host_reader
   import icevga_pkg::*;
#(
   parameter logic [2:0] RD_SLOT     = icevga_pkg::RD_SLOT_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [10:0]        hostBusAddr,
   input  logic [1:0]         bankReg,
   input  logic               nHostRMEM,
   input  logic               nHostVRAMEn,
   input  logic [2:0]         readoutCount,
   input  logic               active,
   input  logic [7:0]         readoutData,
   output logic               vramRdSel,
   output logic [VRAM_AW-1:0] vramRdAddr,
   output logic [7:0]         hostRdData,
   output logic               hostDataOE,
   output logic               hostBusDir
);

   // readoutCount advances once per clk, so the decision is taken one phase
   // early to put the ISSUE cycle exactly on RD_SLOT.
   localparam logic [2:0] PRE_SLOT = RD_SLOT - 3'd1;

   rd_state_t state;
   logic      req_level;
   logic      req_rise;

   // Both strobes are OR-ed before the synchronizer so one chain sees the
   // combined request and there is no skew between two separate chains.
   strobe_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_req_sync (
      .clk     (clk),
      .rst     (rst),
      .strobe_n(nHostRMEM | nHostVRAMEn),
      .level   (req_level),
      .rise    (req_rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vramRdSel  <= 1'b0;
         vramRdAddr <= '0;
         hostRdData <= '0;
         hostDataOE <= 1'b0;
         hostBusDir <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_rise) begin
                  vramRdAddr <= {bankReg, hostBusAddr};
                  state      <= WAIT_SLOT;
               end
            end
            WAIT_SLOT: begin
               if (!req_level) begin
                  state <= IDLE;
               end else if (!active || (readoutCount == PRE_SLOT)) begin
                  vramRdSel <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               vramRdSel <= 1'b0;
               state     <= req_level ? CAPTURE : IDLE;
            end
            CAPTURE: begin
               hostRdData <= readoutData;
               if (req_level) begin
                  hostBusDir <= 1'b0;
                  state      <= DRIVE;
               end else begin
                  state <= IDLE;
               end
            end
            DRIVE: begin
               if (req_level) begin
                  hostDataOE <= 1'b1;
               end else begin
                  // Release the bus one cycle before turning the transceiver.
                  hostDataOE <= 1'b0;
                  state      <= TURN;
               end
            end
            TURN: begin
               hostBusDir <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               vramRdSel  <= 1'b0;
               hostDataOE <= 1'b0;
               hostBusDir <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_host_reader.sv
// Randomized self-checking bench for vram_host_reader with a VRAM/readout
// environment model and timing expectations derived from slot arithmetic.
`timescale 1ns/1ps
module tb_vram_host_reader;

   localparam logic [2:0] RD_SLOT     = 3'd7;
   localparam int         SYNC_STAGES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hostBusAddr;
   logic [1:0]  bankReg;
   logic        nHostRMEM;
   logic        nHostVRAMEn;
   logic [2:0]  readoutCount = 3'd0;
   logic        active;
   logic [7:0]  readoutData = 8'h00;
   logic        vramRdSel;
   logic [12:0] vramRdAddr;
   logic [7:0]  hostRdData;
   logic        hostDataOE;
   logic        hostBusDir;

   logic [7:0]  vram [0:8191];
   logic [12:0] disp_addr = 13'd0;
   logic [12:0] exp_addr  = 13'd0;
   int          cyc       = 0;
   int          n_checks  = 0;
   int          n_fail    = 0;
   int          sel_cnt   = 0;
   int          sel_cyc   = -1;
   int          oe_cyc    = -1;
   bit          oe_seen   = 1'b0;
   bit          oe_prev   = 1'b0;
   int          lat       = 0;

   vram_host_reader #(
      .RD_SLOT    (RD_SLOT),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hostBusAddr (hostBusAddr),
      .bankReg     (bankReg),
      .nHostRMEM   (nHostRMEM),
      .nHostVRAMEn (nHostVRAMEn),
      .readoutCount(readoutCount),
      .active      (active),
      .readoutData (readoutData),
      .vramRdSel   (vramRdSel),
      .vramRdAddr  (vramRdAddr),
      .hostRdData  (hostRdData),
      .hostDataOE  (hostDataOE),
      .hostBusDir  (hostBusDir)
   );

   always #20 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Readout engine and VRAM display port: the phase counter runs while the
   // display fetches, and read data appears one clk after its address.
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      disp_addr   <= disp_addr + 13'd1;
      if (active) readoutCount <= readoutCount + 3'd1;
      readoutData <= vram[vramRdSel ? vramRdAddr : disp_addr];
   end

   always @(negedge clk) begin
      if (vramRdSel) begin
         sel_cnt++;
         sel_cyc = cyc;
         check_val("sel_addr", 32'(vramRdAddr), 32'(exp_addr));
         if (active) check_val("sel_slot", 32'(readoutCount), 32'(RD_SLOT));
      end
      if (hostDataOE && !oe_prev) oe_cyc = cyc;
      if (hostDataOE) oe_seen = 1'b1;
      oe_prev = hostDataOE;
      if (hostDataOE && hostBusDir) check_val("oe_vs_dir", 32'(hostBusDir), 32'd0);
   end

   // Call at a negedge. hold = cycles until strobe release (0: auto, long enough
   // to reach the drive phase).
   task automatic read_txn(input logic [1:0] b, input logic [10:0] a, input logic [7:0] d,
                           input int hold_in, input bit disturb, output int oe_lat);
      int         t0, exp_issue, sel0, hold;
      logic [2:0] rc0;
      bit         exp_oe;
      vram[{b, a}] = d;
      bankReg      = b;
      hostBusAddr  = a;
      exp_addr     = {b, a};
      sel0         = sel_cnt;
      oe_seen      = 1'b0;
      oe_cyc       = -1;
      sel_cyc      = -1;
      t0           = cyc;
      rc0          = readoutCount;
      nHostRMEM    = 1'b0;
      nHostVRAMEn  = 1'b0;
      // Earliest ISSUE: sync stages, edge register, entry into WAIT_SLOT, one wait cycle.
      exp_issue = t0 + SYNC_STAGES + 3;
      if (active) begin
         while (3'(int'(rc0) + exp_issue - t0) != RD_SLOT) exp_issue++;
      end
      hold   = (hold_in == 0) ? (exp_issue - t0 + 1 + int'($urandom_range(0, 7))) : hold_in;
      exp_oe = (hold > exp_issue - t0);
      for (int k = 1; k <= hold + 8; k++) begin
         @(negedge clk);
         if (cyc == t0 + hold) begin
            nHostRMEM   = 1'b1;
            nHostVRAMEn = 1'b1;
         end
         if (disturb && cyc == exp_issue + 5) begin
            bankReg      = ~b;
            hostBusAddr  = ~a;
            vram[{b, a}] = ~d;
         end
         if (exp_oe && cyc == t0 + hold + 2) begin
            check_val("drive_oe", 32'(hostDataOE), 32'd1);
            check_val("drive_dir", 32'(hostBusDir), 32'd0);
         end
         if (exp_oe && cyc == t0 + hold + 3) begin
            check_val("turn_oe", 32'(hostDataOE), 32'd0);
            check_val("turn_dir", 32'(hostBusDir), 32'd0);
         end
         if (cyc == t0 + hold + 4) check_val("idle_dir", 32'(hostBusDir), 32'd1);
      end
      if (exp_oe) begin
         check_val("sel_pulses", 32'(sel_cnt - sel0), 32'd1);
         check_val("issue_cyc", 32'(sel_cyc - t0), 32'(exp_issue - t0));
         check_val("oe_cyc", 32'(oe_cyc - t0), 32'(exp_issue + 3 - t0));
         check_val("rd_data", 32'(hostRdData), 32'(d));
         check_val("rd_addr", 32'(vramRdAddr), 32'({b, a}));
      end else begin
         check_val("abort_no_oe", 32'(oe_seen), 32'd0);
         check_val("abort_dir", 32'(hostBusDir), 32'd1);
      end
      oe_lat = oe_cyc - t0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      nHostRMEM   = 1'b1;
      nHostVRAMEn = 1'b1;
      active      = 1'b0;
      bankReg     = 2'd0;
      hostBusAddr = 11'd0;
      for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      check_val("rst_sel", 32'(vramRdSel), 32'd0);
      check_val("rst_addr", 32'(vramRdAddr), 32'd0);
      check_val("rst_data", 32'(hostRdData), 32'd0);
      check_val("rst_oe", 32'(hostDataOE), 32'd0);
      check_val("rst_dir", 32'(hostBusDir), 32'd1);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Basic read with the display idle.
      active = 1'b0;
      @(negedge clk);
      read_txn(2'd1, 11'h005, 8'hA5, 0, 1'b0, lat);
      check_val("basic_addr", 32'(vramRdAddr), 32'h0805);
      check_val("basic_data", 32'(hostRdData), 32'hA5);

      // Display active, request arrives so the wait spans seven slots.
      active = 1'b1;
      for (int i = 0; i < 16 && readoutCount != 3'd4; i++) @(negedge clk);
      check_val("phase_align", 32'(readoutCount), 32'd4);
      read_txn(2'd2, 11'h123, 8'h5A, 0, 1'b0, lat);
      check_val("slot_latency", 32'(lat), 32'd14);

      // Strobe too short: aborted read.
      active = 1'b0;
      @(negedge clk);
      read_txn(2'd0, 11'h010, 8'h11, 3, 1'b0, lat);

      // Long strobe with explicit turnaround timing.
      read_txn(2'd3, 11'h7FF, 8'hC3, 20, 1'b0, lat);

      // Address and memory change while driving: no re-issue, data held.
      active = 1'b1;
      @(negedge clk);
      read_txn(2'd1, 11'h2AA, 8'h96, 30, 1'b1, lat);

      // Reset while driving the bus.
      active = 1'b0;
      vram[13'h0042] = 8'h3C;
      bankReg     = 2'd0;
      hostBusAddr = 11'h042;
      exp_addr    = 13'h0042;
      @(negedge clk);
      nHostRMEM   = 1'b0;
      nHostVRAMEn = 1'b0;
      for (int i = 0; i < 30 && !hostDataOE; i++) @(negedge clk);
      check_val("pre_rst_oe", 32'(hostDataOE), 32'd1);
      check_val("pre_rst_data", 32'(hostRdData), 32'h3C);
      rst         = 1'b1;
      nHostRMEM   = 1'b1;
      nHostVRAMEn = 1'b1;
      @(negedge clk);
      check_val("drst_oe", 32'(hostDataOE), 32'd0);
      check_val("drst_dir", 32'(hostBusDir), 32'd1);
      check_val("drst_data", 32'(hostRdData), 32'd0);
      check_val("drst_addr", 32'(vramRdAddr), 32'd0);
      rst     = 1'b0;
      oe_seen = 1'b0;
      repeat (10) @(negedge clk);
      check_val("post_rst_oe", 32'(oe_seen), 32'd0);
      check_val("post_rst_dir", 32'(hostBusDir), 32'd1);

      // Randomized reads, occasionally aborted.
      for (int n = 0; n < 14; n++) begin
         active = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 8)) @(negedge clk);
         read_txn(2'($urandom), 11'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0, lat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
